// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with sequential/branch/jump/jr/stall
// next-PC selection and a circular return-address stack with sticky flags.
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [15:0]       branch_off_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_idx_i,
    input  logic              jump_reg_i,
    input  logic [ADDR_W-1:0] jr_target_i,
    input  logic              link_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic [1:0]        ras_err_o,
    output logic              misalign_o
);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RAS_DEPTH);
    // Bits of the PC replaced by a J-type target ({jump_idx, 2'b00}).
    localparam logic [ADDR_W-1:0] JMP_MASK = ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;     // index of the top entry
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        err_q, err_d;
    logic              mis_q, mis_d;

    logic [ADDR_W-1:0] pc_plus4, br_tgt, jmp_tgt, target;
    logic              push, pop, has_entry;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;

    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign br_tgt    = pc_plus4 + {{(ADDR_W-18){branch_off_i[15]}}, branch_off_i, 2'b00};
    assign jmp_tgt   = (pc_plus4 & ~JMP_MASK) | ADDR_W'({jump_idx_i, 2'b00});
    // link/ret only mean something alongside the matching jump kind.
    assign push      = link_i & (jump_i | jump_reg_i);
    assign pop       = ret_i & jump_reg_i;
    assign has_entry = (cnt_q != '0);

    // Priority target select; ret falls back to jr_target on an empty stack.
    always_comb begin
        target = pc_plus4;
        if (jump_reg_i && ret_i)  target = has_entry ? ras_q[ptr_q] : jr_target_i;
        else if (jump_reg_i)      target = jr_target_i;
        else if (jump_i)          target = jmp_tgt;
        else if (branch_taken_i)  target = br_tgt;
    end

    // Next-state for PC, stack pointer/count and sticky flags; stall freezes all.
    always_comb begin
        pc_d   = pc_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        mis_d  = mis_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (!stall_i) begin
            pc_d = {target[ADDR_W-1:2], 2'b00};
            if (target[1:0] != 2'b00) mis_d = 1'b1;
            if (push && pop) begin
                // jalr $ra: return through the top, then replace it with the new link.
                wr_en = 1'b1;
                if (!has_entry) begin
                    cnt_d    = CNT_W'(1);
                    err_d[1] = 1'b1;
                end
            end else if (push) begin
                // Pointer wrap makes a push when full overwrite the oldest entry.
                wr_en  = 1'b1;
                wr_idx = ptr_q + PTR_W'(1);
                ptr_d  = ptr_q + PTR_W'(1);
                if (cnt_q == DEPTH_C) err_d[0] = 1'b1;
                else                  cnt_d    = cnt_q + CNT_W'(1);
            end else if (pop) begin
                if (has_entry) begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    err_d[1] = 1'b1;
                end
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q  <= RESET_VEC;
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            mis_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            mis_q <= mis_d;
            if (wr_en) ras_q[wr_idx] <= pc_plus4;
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4;
    assign ras_empty_o = (cnt_q == '0);
    assign ras_full_o  = (cnt_q == DEPTH_C);
    assign ras_err_o   = err_q;
    assign misalign_o  = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset corner case, and a
// randomized run against a queue-based reference model.
module tb_pc_sequencer;
    localparam logic [31:0] RV = 32'h0040_0000;
    localparam int D = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stall = 0, br = 0, jmp = 0, jr = 0, link = 0, ret = 0;
    logic [15:0] off = '0;
    logic [25:0] idx = '0;
    logic [31:0] jrt = '0;
    logic [31:0] pc, pp4;
    logic        empty, full, mis;
    logic [1:0]  err;

    pc_sequencer #(.ADDR_W(32), .RESET_VEC(RV), .RAS_DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
        .branch_off_i(off), .jump_i(jmp), .jump_idx_i(idx), .jump_reg_i(jr),
        .jr_target_i(jrt), .link_i(link), .ret_i(ret), .pc_o(pc),
        .pc_plus4_o(pp4), .ras_empty_o(empty), .ras_full_o(full),
        .ras_err_o(err), .misalign_o(mis));

    always #5 clk = ~clk;

    typedef struct {
        logic st, b; logic [15:0] o; logic j; logic [25:0] ix;
        logic r; logic [31:0] t; logic l, rt;
        logic [31:0] e_pc; logic e_empty, e_full; logic [1:0] e_err; logic e_mis;
    } vec_t;

    int total = 0, passed = 0;

    // Reference model: PC value, stack as a queue (back = top), sticky flags.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic [1:0]  m_err;
    logic        m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pc = RV; m_q.delete(); m_err = 2'b00; m_mis = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] p4, tgt;
        logic psh, pp;
        if (stall) return;
        p4 = m_pc + 32'd4;
        if (jr && ret)  tgt = (m_q.size() > 0) ? m_q[m_q.size()-1] : jrt;
        else if (jr)    tgt = jrt;
        else if (jmp)   tgt = {p4[31:28], idx, 2'b00};
        else if (br)    tgt = p4 + 32'(signed'(off)) * 4;
        else            tgt = p4;
        if (tgt % 4 != 0) m_mis = 1'b1;
        m_pc = tgt & ~32'd3;
        psh = link && (jmp || jr);
        pp  = ret && jr;
        if (psh && pp) begin
            if (m_q.size() == 0) begin m_err[1] = 1'b1; m_q.push_back(p4); end
            else m_q[m_q.size()-1] = p4;
        end else if (psh) begin
            if (m_q.size() == D) begin void'(m_q.pop_front()); m_err[0] = 1'b1; end
            m_q.push_back(p4);
        end else if (pp) begin
            if (m_q.size() == 0) m_err[1] = 1'b1;
            else void'(m_q.pop_back());
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, " pc"},    pc, m_pc);
        chk({tag, " pc+4"},  pp4, m_pc + 32'd4);
        chk({tag, " empty"}, 32'(empty), 32'(m_q.size() == 0));
        chk({tag, " full"},  32'(full), 32'(m_q.size() == D));
        chk({tag, " err"},   32'(err), 32'(m_err));
        chk({tag, " mis"},   32'(mis), 32'(m_mis));
    endtask

    task automatic apply(input vec_t v);
        stall = v.st; br = v.b; off = v.o; jmp = v.j; idx = v.ix;
        jr = v.r; jrt = v.t; link = v.l; ret = v.rt;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1 model_cmp(tag);
    endtask

    function automatic vec_t mk(input logic st, b, input logic [15:0] o, input logic j,
                                input logic [25:0] ix, input logic r, input logic [31:0] t,
                                input logic l, rt, input logic [31:0] e_pc,
                                input logic e_empty, e_full, input logic [1:0] e_err,
                                input logic e_mis);
        vec_t v;
        v.st = st; v.b = b; v.o = o; v.j = j; v.ix = ix; v.r = r; v.t = t;
        v.l = l; v.rt = rt; v.e_pc = e_pc; v.e_empty = e_empty; v.e_full = e_full;
        v.e_err = e_err; v.e_mis = e_mis;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        //          st b  off      j  idx      r  jrt          l  rt  e_pc         E  F  err   mis
        tbl[0]  = mk(0,0,16'h0000,0,26'h000,0,32'h0,      0,0, 32'h0040_0004,1,0,2'b00,0);
        tbl[1]  = mk(0,0,16'h0000,0,26'h000,0,32'h0,      0,0, 32'h0040_0008,1,0,2'b00,0);
        tbl[2]  = mk(0,0,16'h0000,0,26'h000,0,32'h0,      0,0, 32'h0040_000C,1,0,2'b00,0);
        tbl[3]  = mk(0,0,16'h0000,1,26'h040,0,32'h0,      0,0, 32'h0000_0100,1,0,2'b00,0);
        tbl[4]  = mk(0,1,16'hFFFE,0,26'h000,0,32'h0,      0,0, 32'h0000_00FC,1,0,2'b00,0);
        tbl[5]  = mk(0,1,16'h0010,1,26'h040,0,32'h0,      0,0, 32'h0000_0100,1,0,2'b00,0);
        tbl[6]  = mk(0,0,16'h0000,1,26'h080,0,32'h0,      0,0, 32'h0000_0200,1,0,2'b00,0);
        tbl[7]  = mk(1,0,16'h0000,1,26'h010,0,32'h0,      1,0, 32'h0000_0200,1,0,2'b00,0);
        tbl[8]  = mk(0,0,16'h0000,1,26'h010,0,32'h0,      0,0, 32'h0000_0040,1,0,2'b00,0);
        tbl[9]  = mk(0,0,16'h0000,1,26'h004,0,32'h0,      0,0, 32'h0000_0010,1,0,2'b00,0);
        tbl[10] = mk(0,0,16'h0000,1,26'h008,0,32'h0,      1,0, 32'h0000_0020,0,0,2'b00,0);
        tbl[11] = mk(0,0,16'h0000,1,26'h00C,0,32'h0,      1,0, 32'h0000_0030,0,0,2'b00,0);
        tbl[12] = mk(0,0,16'h0000,1,26'h010,0,32'h0,      1,0, 32'h0000_0040,0,0,2'b00,0);
        tbl[13] = mk(0,0,16'h0000,1,26'h014,0,32'h0,      1,0, 32'h0000_0050,0,1,2'b00,0);
        tbl[14] = mk(0,0,16'h0000,1,26'h100,0,32'h0,      1,0, 32'h0000_0400,0,1,2'b01,0);
        tbl[15] = mk(0,0,16'h0000,0,26'h000,1,32'h0,      0,1, 32'h0000_0054,0,0,2'b01,0);
        tbl[16] = mk(0,0,16'h0000,0,26'h000,1,32'h0,      0,1, 32'h0000_0044,0,0,2'b01,0);
        tbl[17] = mk(0,0,16'h0000,0,26'h000,1,32'h0,      0,1, 32'h0000_0034,0,0,2'b01,0);
        tbl[18] = mk(0,0,16'h0000,0,26'h000,1,32'h0,      0,1, 32'h0000_0024,1,0,2'b01,0);
        tbl[19] = mk(0,0,16'h0000,0,26'h000,1,32'h800,    0,1, 32'h0000_0800,1,0,2'b11,0);
        tbl[20] = mk(0,0,16'h0000,0,26'h000,1,32'h1003,   0,0, 32'h0000_1000,1,0,2'b11,1);
        tbl[21] = mk(0,0,16'h0000,0,26'h000,0,32'h0,      0,0, 32'h0000_1004,1,0,2'b11,1);
        tbl[22] = mk(0,0,16'h0000,0,26'h000,0,32'h0,      0,0, 32'h0000_1008,1,0,2'b11,1);

        // Reset state.
        model_reset();
        #12;
        chk("rst pc", pc, RV);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst mis", 32'(mis), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 23; i++) begin
            apply(tbl[i]);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].e_full));
            chk($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].e_err));
            chk($sformatf("vec%0d mis", i), 32'(mis), 32'(tbl[i].e_mis));
        end

        // Async reset mid-cycle during a jal push.
        apply(mk(0,0,16'h0,1,26'h040,0,32'h0,1,0, 32'h0,0,0,2'b00,0));
        step("pre-rst jal");
        chk("pre-rst nonempty", 32'(empty), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst pc", pc, RV);
        chk("async rst empty", 32'(empty), 32'd1);
        chk("async rst err", 32'(err), 32'd0);
        chk("async rst mis", 32'(mis), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst hold pc", pc, RV);
            chk("rst hold empty", 32'(empty), 32'd1);
        end
        model_reset();
        apply(mk(0,0,16'h0,0,26'h0,0,32'h0,0,0, 32'h0,0,0,2'b00,0));
        @(negedge clk) rst_n = 1'b1;
        step("post-rst idle");
        chk("post-rst pc", pc, RV + 32'd4);

        // jalr on an empty stack: fallback target, underflow flag, count becomes 1.
        apply(mk(0,0,16'h0,0,26'h0,1,32'h300,1,1, 32'h0,0,0,2'b00,0));
        step("jalr empty");
        chk("jalr empty pc", pc, 32'h300);
        chk("jalr empty err", 32'(err), 32'd2);
        chk("jalr empty count1", 32'(empty), 32'd0);

        // Randomized run against the model.
        for (int n = 0; n < 600; n++) begin
            stall = ($urandom % 8) == 0;
            br    = ($urandom % 3) == 0;
            off   = 16'($urandom);
            jmp   = ($urandom % 5) == 0;
            idx   = 26'($urandom);
            jr    = ($urandom % 4) == 0;
            jrt   = $urandom;
            if (($urandom % 8) != 0) jrt[1:0] = 2'b00;
            link  = ($urandom % 2) == 0;
            ret   = ($urandom % 2) == 0;
            if (n == 300) begin
                rst_n = 1'b0; model_reset(); #1 rst_n = 1'b1;
            end
            step($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
